// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync marker 1,0,1, then a WIDTH-bit payload MSB-first,
// then GAP_BITS idle zeros. The word is taken through a valid/ready handshake in IDLE.
//
// state | meaning
// IDLE  | waiting for a word; data_ready high
// SYNC  | driving marker bits 1,0,1
// DATA  | driving the payload, MSB first
// GAP   | driving idle zeros between frames
module sync_frame_tx #(
    parameter int WIDTH    = 8,
    parameter int GAP_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             output_bit,
    output logic             bit_valid,
    output logic [1:0]       state
);

    localparam int MAXC = (WIDTH > 3) ? ((WIDTH > GAP_BITS) ? WIDTH : GAP_BITS)
                                      : ((GAP_BITS > 3) ? GAP_BITS : 3);
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SYNC_LAST = CW'(2);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;

    // Outputs are computed for the cycle being entered so they stay aligned with state.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bit_d   = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d = SYNC;
                    shreg_d = data_in;
                    cnt_d   = '0;
                    bit_d   = 1'b1;
                    valid_d = 1'b1;
                end
            end
            SYNC: begin
                valid_d = 1'b1;
                if (cnt_q == SYNC_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    bit_d = (cnt_q == CW'(1));
                end
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (GAP_BITS > 0) state_d = GAP;
                    else              state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    bit_d   = shreg_q[WIDTH-1];
                    valid_d = 1'b1;
                    shreg_d = shreg_q << 1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
        end
    end

    assign data_ready = !rst && (state_q == IDLE);
    assign output_bit = bit_q;
    assign bit_valid  = valid_q;
    assign state      = state_q;

endmodule
